// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch front end for the 8-bit core.
// Owns the PC, addresses the instruction ROM, registers the fetched word into
// the IF/ID register, applies taken branches with a one-slot flush, and
// raises done when the HALT encoding is fetched.
module fetch_stage #(
    parameter int unsigned             PC_W        = 10,
    parameter int unsigned             INSTR_W     = 9,
    parameter int unsigned             START_ADDR  = 0,
    parameter logic [INSTR_W-1:0]      HALT_OPCODE = 9'h1FF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stall,
    input  logic                branch_en,
    input  logic                abs_jump,
    input  logic [PC_W-1:0]     target,
    input  logic [INSTR_W-1:0]  instr_in,
    output logic [PC_W-1:0]     pc,
    output logic [INSTR_W-1:0]  instr_out,
    output logic                instr_valid,
    output logic                done
);

    localparam logic [PC_W-1:0]    PC_START = PC_W'(START_ADDR);
    localparam logic [PC_W-1:0]    PC_ONE   = PC_W'(1);
    localparam logic [INSTR_W-1:0] INSTR_Z  = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;

    // Address of the word currently in IF/ID; base for relative branches.
    logic [PC_W-1:0]      pc_br_c;
    // Branch destination, absolute or PC-relative (wraps modulo 2**PC_W).
    logic [PC_W-1:0]      br_target_c;
    logic                 is_halt_c;

    // Branch target and HALT decode on the word being fetched.
    always_comb begin
        pc_br_c     = pc_q - PC_ONE;
        br_target_c = abs_jump ? target : (pc_br_c + target);
        is_halt_c   = (instr_in == HALT_OPCODE);
    end

    // Next-state logic: stall > branch > HALT detect > sequential in RUN.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        done_d  = done_q;

        unique case (state_q)
            ST_RUN: begin
                if (stall) begin
                    // Everything holds; decode keeps branch_en up meanwhile.
                end else if (branch_en) begin
                    pc_d    = br_target_c;
                    valid_d = 1'b0;
                end else if (is_halt_c) begin
                    instr_d = HALT_OPCODE;
                    valid_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    instr_d = instr_in;
                    valid_d = 1'b1;
                    pc_d    = pc_q + PC_ONE;
                end
            end
            default: begin
                // IDLE and HALT: only start moves us; no real instruction out.
                valid_d = 1'b0;
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = PC_START;
                    done_d  = 1'b0;
                end
            end
        endcase
    end

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= PC_START;
            instr_q <= INSTR_Z;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign pc          = pc_q;
    assign instr_out   = instr_q;
    assign instr_valid = valid_q;
    assign done        = done_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven cycle vectors with a scoreboard queue of
// expected outputs, plus a hand-written stall-on-HALT sequence.
module tb_fetch_stage;

    localparam int unsigned PC_W    = 10;
    localparam int unsigned INSTR_W = 9;

    logic               clk;
    logic               reset;
    logic               start;
    logic               stall;
    logic               branch_en;
    logic               abs_jump;
    logic [PC_W-1:0]    target;
    logic [INSTR_W-1:0] instr_in;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr_out;
    logic               instr_valid;
    logic               done;

    logic [INSTR_W-1:0] rom [1024];

    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stall       (stall),
        .branch_en   (branch_en),
        .abs_jump    (abs_jump),
        .target      (target),
        .instr_in    (instr_in),
        .pc          (pc),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .done        (done)
    );

    assign instr_in = rom[pc];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic               r;
        logic               s;
        logic               st;
        logic               br;
        logic               ab;
        logic [PC_W-1:0]    tgt;
        logic [PC_W-1:0]    e_pc;
        logic [INSTR_W-1:0] e_instr;
        logic               e_valid;
        logic               e_done;
    } vec_t;

    typedef struct {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               valid;
        logic               done;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic add(input logic r, input logic s, input logic st, input logic br,
                       input logic ab, input logic [PC_W-1:0] tgt,
                       input logic [PC_W-1:0] e_pc, input logic [INSTR_W-1:0] e_instr,
                       input logic e_valid, input logic e_done);
        vec_t v;
        v.r = r; v.s = s; v.st = st; v.br = br; v.ab = ab; v.tgt = tgt;
        v.e_pc = e_pc; v.e_instr = e_instr; v.e_valid = e_valid; v.e_done = e_done;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, queue the expectation, compare after the edge.
    task automatic step(input string name, input vec_t v);
        exp_t e;
        exp_t got;
        @(negedge clk);
        reset     = v.r;
        start     = v.s;
        stall     = v.st;
        branch_en = v.br;
        abs_jump  = v.ab;
        target    = v.tgt;
        e.pc = v.e_pc; e.instr = v.e_instr; e.valid = v.e_valid; e.done = v.e_done;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got.pc = pc; got.instr = instr_out; got.valid = instr_valid; got.done = done;
        e = sb.pop_front();
        n_checks++;
        if (got.pc == e.pc && got.instr == e.instr && got.valid == e.valid && got.done == e.done) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got pc=%h instr=%h valid=%b done=%b, required pc=%h instr=%h valid=%b done=%b",
                     name, got.pc, got.instr, got.valid, got.done, e.pc, e.instr, e.valid, e.done);
        end
    endtask

    task automatic hstep(input string name, input logic r, input logic s, input logic st,
                         input logic [PC_W-1:0] e_pc, input logic [INSTR_W-1:0] e_instr,
                         input logic e_valid, input logic e_done);
        vec_t v;
        v.r = r; v.s = s; v.st = st; v.br = 1'b0; v.ab = 1'b0; v.tgt = '0;
        v.e_pc = e_pc; v.e_instr = e_instr; v.e_valid = e_valid; v.e_done = e_done;
        step(name, v);
    endtask

    initial begin
        // ROM: word at address a is its low 8 bits, so never the HALT encoding.
        for (int a = 0; a < 1024; a++) rom[a] = {1'b0, 8'(a)};
        rom[0]  = 9'h001;
        rom[1]  = 9'h002;
        rom[2]  = 9'h003;
        rom[3]  = 9'h1FF;
        rom[50] = 9'h1FF;

        reset = 1'b1; start = 1'b0; stall = 1'b0;
        branch_en = 1'b0; abs_jump = 1'b0; target = '0;

        //   r  s  st br ab tgt      pc       instr    v  d
        add(1, 0, 0, 0, 0, 10'd0,   10'd0,   9'h000, 0, 0); // reset
        add(0, 0, 0, 0, 0, 10'd0,   10'd0,   9'h000, 0, 0); // idle hold
        add(0, 1, 0, 0, 0, 10'd0,   10'd0,   9'h000, 0, 0); // start
        add(0, 0, 0, 0, 0, 10'd0,   10'd1,   9'h001, 1, 0);
        add(0, 0, 0, 0, 0, 10'd0,   10'd2,   9'h002, 1, 0);
        add(0, 0, 0, 0, 0, 10'd0,   10'd3,   9'h003, 1, 0);
        add(0, 0, 0, 0, 0, 10'd0,   10'd3,   9'h1FF, 1, 1); // HALT fetched
        add(0, 0, 0, 0, 0, 10'd0,   10'd3,   9'h1FF, 0, 1);
        add(0, 1, 0, 0, 0, 10'd0,   10'd0,   9'h1FF, 0, 0); // restart
        add(0, 0, 0, 0, 0, 10'd0,   10'd1,   9'h001, 1, 0);
        add(0, 0, 0, 1, 1, 10'd4,   10'd4,   9'h001, 0, 0); // abs jump to 4
        add(0, 0, 0, 0, 0, 10'd0,   10'd5,   9'h004, 1, 0);
        add(0, 0, 0, 0, 0, 10'd0,   10'd6,   9'h005, 1, 0);
        add(0, 0, 0, 1, 1, 10'd20,  10'd20,  9'h005, 0, 0); // from addr 5 to 20
        add(0, 0, 0, 0, 0, 10'd0,   10'd21,  9'h014, 1, 0);
        add(0, 0, 0, 1, 1, 10'd8,   10'd8,   9'h014, 0, 0);
        add(0, 0, 0, 0, 0, 10'd0,   10'd9,   9'h008, 1, 0);
        add(0, 0, 0, 1, 0, 10'h3FD, 10'd5,   9'h008, 0, 0); // rel -3 from 8
        add(0, 0, 0, 0, 0, 10'd0,   10'd6,   9'h005, 1, 0);
        add(0, 0, 0, 1, 1, 10'd1,   10'd1,   9'h005, 0, 0);
        add(0, 0, 0, 0, 0, 10'd0,   10'd2,   9'h002, 1, 0);
        add(0, 0, 0, 1, 0, 10'h3FC, 10'h3FD, 9'h002, 0, 0); // rel -4 from 1 wraps
        add(0, 0, 0, 0, 0, 10'd0,   10'h3FE, 9'h0FD, 1, 0);
        add(0, 0, 0, 0, 0, 10'd0,   10'h3FF, 9'h0FE, 1, 0);
        add(0, 0, 0, 0, 0, 10'd0,   10'h000, 9'h0FF, 1, 0); // pc wraps to 0
        add(0, 0, 0, 0, 0, 10'd0,   10'd1,   9'h001, 1, 0);
        add(0, 0, 1, 1, 1, 10'd30,  10'd1,   9'h001, 1, 0); // stall over branch
        add(0, 0, 1, 1, 1, 10'd30,  10'd1,   9'h001, 1, 0);
        add(0, 0, 1, 1, 1, 10'd30,  10'd1,   9'h001, 1, 0);
        add(0, 0, 0, 1, 1, 10'd30,  10'd30,  9'h001, 0, 0); // branch on release
        add(0, 0, 0, 0, 0, 10'd0,   10'd31,  9'h01E, 1, 0);
        add(0, 0, 0, 1, 1, 10'd49,  10'd49,  9'h01E, 0, 0);
        add(0, 0, 0, 0, 0, 10'd0,   10'd50,  9'h031, 1, 0);
        add(0, 0, 0, 1, 1, 10'd60,  10'd60,  9'h031, 0, 0); // HALT at 50 flushed
        add(0, 0, 0, 0, 0, 10'd0,   10'd61,  9'h03C, 1, 0);
        add(0, 0, 1, 0, 0, 10'd0,   10'd61,  9'h03C, 1, 0); // plain stall
        add(1, 0, 0, 0, 0, 10'd0,   10'd0,   9'h000, 0, 0); // reset mid-run
        add(0, 0, 0, 0, 0, 10'd0,   10'd0,   9'h000, 0, 0);
        add(0, 1, 0, 0, 0, 10'd0,   10'd0,   9'h000, 0, 0);
        add(0, 1, 0, 0, 0, 10'd0,   10'd1,   9'h001, 1, 0); // start ignored in RUN
        add(0, 0, 0, 0, 0, 10'd0,   10'd2,   9'h002, 1, 0);
        add(0, 0, 0, 0, 0, 10'd0,   10'd3,   9'h003, 1, 0);
        add(0, 0, 0, 0, 0, 10'd0,   10'd3,   9'h1FF, 1, 1);
        add(0, 0, 1, 0, 0, 10'd0,   10'd3,   9'h1FF, 0, 1);
        add(1, 0, 0, 0, 0, 10'd0,   10'd0,   9'h000, 0, 0); // reset in HALT
        add(1, 1, 0, 0, 0, 10'd0,   10'd0,   9'h000, 0, 0); // reset beats start
        add(0, 0, 0, 0, 0, 10'd0,   10'd0,   9'h000, 0, 0); // still idle
        add(0, 1, 0, 0, 0, 10'd0,   10'd0,   9'h000, 0, 0);
        add(0, 0, 0, 0, 0, 10'd0,   10'd1,   9'h001, 1, 0);
        add(1, 0, 1, 1, 1, 10'd9,   10'd0,   9'h000, 0, 0); // reset mid-stall

        foreach (vecs[i]) step($sformatf("vec%0d", i), vecs[i]);

        // Stall while the HALT word sits at the ROM port: no early done.
        hstep("h_start",   0, 1, 0, 10'd0, 9'h000, 0, 0);
        hstep("h_f0",      0, 0, 0, 10'd1, 9'h001, 1, 0);
        hstep("h_f1",      0, 0, 0, 10'd2, 9'h002, 1, 0);
        hstep("h_f2",      0, 0, 0, 10'd3, 9'h003, 1, 0);
        hstep("h_stall0",  0, 0, 1, 10'd3, 9'h003, 1, 0);
        hstep("h_stall1",  0, 0, 1, 10'd3, 9'h003, 1, 0);
        hstep("h_halt",    0, 0, 0, 10'd3, 9'h1FF, 1, 1);
        hstep("h_restart", 0, 1, 0, 10'd0, 9'h1FF, 0, 0);
        hstep("h_refetch", 0, 0, 0, 10'd1, 9'h001, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
